// File: rtl/soc_simple_pll_pkg.sv
// Shared types and default constants for the PLL lock manager.
package soc_simple_pll_pkg;

    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } pll_state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 65535;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int RELOCK_W           = 8;

endpackage

// File: rtl/soc_simple_pll_lock_mgr_if.sv
// Control/status bundle between the PLL lock manager and its user.
interface soc_simple_pll_lock_mgr_if;
    import soc_simple_pll_pkg::*;

    logic                pll_locked;
    logic                sw_reset_req;
    logic                lock_lost_clr;
    logic                pll_rst;
    logic                sys_rst_n;
    logic                lock_lost;
    logic [RELOCK_W-1:0] relock_count;

    modport master (
        output pll_locked, sw_reset_req, lock_lost_clr,
        input  pll_rst, sys_rst_n, lock_lost, relock_count
    );

    modport slave (
        input  pll_locked, sw_reset_req, lock_lost_clr,
        output pll_rst, sys_rst_n, lock_lost, relock_count
    );

endinterface

// File: rtl/soc_simple_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
module soc_simple_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/soc_simple_pll_lock_mgr.sv
// PLL reset/lock sequencer; SOC_PLL_LOCK_STATS_EN enables lock_lost
// and relock_count tracking (tied to zero otherwise).
module soc_simple_pll_lock_mgr
    import soc_simple_pll_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES
) (
    input logic                      refclk,
    input logic                      rst_n,
    soc_simple_pll_lock_mgr_if.slave bus
);

    localparam logic [31:0] RST_LAST = 32'(PLL_RST_CYCLES - 1);
    localparam logic [31:0] TO_LAST  = 32'(LOCK_TIMEOUT - 1);
    localparam logic [31:0] STB_LAST = 32'(STABLE_CYCLES - 1);

    pll_state_t  state;
    logic [31:0] cnt;
    logic        lk;
    logic        pll_rst_q;
    logic        sys_rst_q;

    soc_simple_sync2 #(.WIDTH(1)) u_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (bus.pll_locked),
        .q     (lk)
    );

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b0;
        end else if (bus.sw_reset_req) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b0;
        end else begin
            unique case (state)
                S_PLL_RST: begin
                    if (cnt == RST_LAST) begin
                        state     <= S_WAIT_LOCK;
                        cnt       <= '0;
                        pll_rst_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lk) begin
                        state <= S_STABLE;
                        cnt   <= '0;
                    end else if (cnt == TO_LAST) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_STABLE: begin
                    if (!lk) begin
                        state <= S_WAIT_LOCK;
                        cnt   <= '0;
                    end else if (cnt == STB_LAST) begin
                        state     <= S_RUN;
                        cnt       <= '0;
                        sys_rst_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                S_RUN: begin
                    if (!lk) begin
                        state     <= S_PLL_RST;
                        cnt       <= '0;
                        pll_rst_q <= 1'b1;
                        sys_rst_q <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_PLL_RST;
                    cnt       <= '0;
                    pll_rst_q <= 1'b1;
                    sys_rst_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pll_rst   = pll_rst_q;
    assign bus.sys_rst_n = sys_rst_q;

`ifdef SOC_PLL_LOCK_STATS_EN
    logic                lost_q;
    logic [RELOCK_W-1:0] relock_q;
    logic                lost_evt;

    // Loss is judged on the RUN-state lock alone, so a coincident
    // software reset still records it.
    assign lost_evt = (state == S_RUN) && !lk;

    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lost_q   <= 1'b0;
            relock_q <= '0;
        end else begin
            if (lost_evt) begin
                lost_q <= 1'b1;
            end else if (bus.lock_lost_clr) begin
                lost_q <= 1'b0;
            end
            if (lost_evt && (relock_q != '1)) begin
                relock_q <= relock_q + 1'b1;
            end
        end
    end

    assign bus.lock_lost    = lost_q;
    assign bus.relock_count = relock_q;
`else
    logic unused_clr;

    assign unused_clr       = bus.lock_lost_clr;
    assign bus.lock_lost    = 1'b0;
    assign bus.relock_count = '0;
`endif

endmodule

// File: tb/tb_soc_simple_pll_lock_mgr.sv
// Directed bench for soc_simple_pll_lock_mgr (RST=4, TIMEOUT=20, STABLE=8).
module tb_soc_simple_pll_lock_mgr;

`ifdef SOC_PLL_LOCK_STATS_EN
    localparam int ST = 1;
`else
    localparam int ST = 0;
`endif

    logic refclk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n;
    int   tmo;
    logic sys_hi;

    soc_simple_pll_lock_mgr_if bus ();

    soc_simple_pll_lock_mgr #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (20),
        .STABLE_CYCLES  (8)
    ) dut (
        .refclk (refclk),
        .rst_n  (rst_n),
        .bus    (bus.slave)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic run_len(input logic v, input int max, output int len);
        len = 0;
        while (bus.pll_rst === v && len < max) begin
            len++;
            if (bus.sys_rst_n !== 1'b0) sys_hi = 1'b1;
            @(negedge refclk);
        end
    endtask

    task automatic wait_sys(input int max, output int len);
        len = 0;
        while (bus.sys_rst_n !== 1'b1 && len < max) begin
            @(negedge refclk);
            len++;
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        tmo     = 0;
        sys_hi  = 1'b0;
        rst_n   = 1'b0;
        bus.pll_locked    = 1'b0;
        bus.sw_reset_req  = 1'b0;
        bus.lock_lost_clr = 1'b0;
        repeat (3) @(negedge refclk);
        check("rst_pll_rst", 32'(bus.pll_rst), 1);
        check("rst_sys_rst_n", 32'(bus.sys_rst_n), 0);
        check("rst_lock_lost", 32'(bus.lock_lost), 0);
        check("rst_relock", 32'(bus.relock_count), 0);

        // Power-up: 4-cycle PLL reset, lock 10 cycles after release
        rst_n = 1'b1;
        run_len(1'b1, 50, n);
        check("pwr_rst_pulse", n, 4);
        repeat (6) @(negedge refclk);
        bus.pll_locked = 1'b1;
        wait_sys(50, n);
        check("lock_to_run", n, 11);
        check("run_pll_rst", 32'(bus.pll_rst), 0);

        // Software reset in RUN
        bus.sw_reset_req = 1'b1;
        @(negedge refclk);
        bus.sw_reset_req = 1'b0;
        check("sw_sys_rst_n", 32'(bus.sys_rst_n), 0);
        run_len(1'b1, 50, n);
        check("sw_rst_pulse", n, 4);
        check("sw_relock", 32'(bus.relock_count), 0);
        check("sw_lock_lost", 32'(bus.lock_lost), 0);
        wait_sys(50, n);
        check("sw_to_run", n, 9);

        // First lock loss in RUN
        bus.pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("drop_sys_rst_n", 32'(bus.sys_rst_n), 0);
        check("drop_pll_rst", 32'(bus.pll_rst), 1);
        check("drop_lock_lost", 32'(bus.lock_lost), ST);
        check("drop_relock", 32'(bus.relock_count), ST);
        bus.pll_locked = 1'b1;
        wait_sys(50, n);
        check("relock_time", n, 13);
        bus.lock_lost_clr = 1'b1;
        @(negedge refclk);
        bus.lock_lost_clr = 1'b0;
        check("clr_lock_lost", 32'(bus.lock_lost), 0);
        check("clr_relock", 32'(bus.relock_count), ST);

        // Clear held across a loss event: set must win
        bus.lock_lost_clr = 1'b1;
        bus.pll_locked    = 1'b0;
        repeat (3) @(negedge refclk);
        check("setwin_lock_lost", 32'(bus.lock_lost), ST);
        @(negedge refclk);
        check("setwin_cleared", 32'(bus.lock_lost), 0);
        bus.lock_lost_clr = 1'b0;
        bus.pll_locked    = 1'b1;
        wait_sys(50, n);
        if (n >= 50) tmo++;

        // Software reset coinciding with the lock drop
        bus.pll_locked = 1'b0;
        repeat (2) @(negedge refclk);
        bus.sw_reset_req = 1'b1;
        @(negedge refclk);
        bus.sw_reset_req = 1'b0;
        check("combo_pll_rst", 32'(bus.pll_rst), 1);
        check("combo_lock_lost", 32'(bus.lock_lost), ST);
        check("combo_relock", 32'(bus.relock_count), 3 * ST);
        bus.pll_locked = 1'b1;
        wait_sys(50, n);
        if (n >= 50) tmo++;

        // Remaining 297 losses to reach 300 total
        for (int i = 0; i < 297; i++) begin
            bus.pll_locked = 1'b0;
            repeat (3) @(negedge refclk);
            bus.pll_locked = 1'b1;
            wait_sys(50, n);
            if (n >= 50) tmo++;
        end
        check("relock_timeouts", tmo, 0);
        check("sat_relock", 32'(bus.relock_count), 255 * ST);
        check("sat_lock_lost", 32'(bus.lock_lost), ST);
        bus.lock_lost_clr = 1'b1;
        @(negedge refclk);
        bus.lock_lost_clr = 1'b0;
        check("sat_clr_lost", 32'(bus.lock_lost), 0);
        check("sat_keep_relock", 32'(bus.relock_count), 255 * ST);

        // Asynchronous reset mid-STABLE
        bus.pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        bus.pll_locked = 1'b1;
        repeat (7) @(negedge refclk);
        check("pre_rst_sys", 32'(bus.sys_rst_n), 0);
        check("pre_rst_pll", 32'(bus.pll_rst), 0);
        check("pre_rst_lost", 32'(bus.lock_lost), ST);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_pll_rst", 32'(bus.pll_rst), 1);
        check("async_sys_rst_n", 32'(bus.sys_rst_n), 0);
        check("async_lock_lost", 32'(bus.lock_lost), 0);
        check("async_relock", 32'(bus.relock_count), 0);

        // No lock: PLL reset re-pulses every 24 cycles
        bus.pll_locked = 1'b0;
        @(negedge refclk);
        rst_n  = 1'b1;
        sys_hi = 1'b0;
        run_len(1'b1, 50, n);
        check("nolock_pulse1", n, 4);
        run_len(1'b0, 50, n);
        check("nolock_wait", n, 20);
        run_len(1'b1, 50, n);
        check("nolock_pulse2", n, 4);
        check("nolock_sys_low", 32'(sys_hi), 0);

        // Lock glitch during STABLE
        bus.pll_locked = 1'b1;
        repeat (5) @(negedge refclk);
        bus.pll_locked = 1'b0;
        repeat (3) @(negedge refclk);
        check("glitch_sys_low", 32'(bus.sys_rst_n), 0);
        bus.pll_locked = 1'b1;
        wait_sys(50, n);
        check("glitch_release", n, 11);
        check("glitch_pll_rst", 32'(bus.pll_rst), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
